// File: rtl/kbd_pkg.sv
// Shared constants, parser state and event record for the PS/2 scan-code decoder.
package kbd_pkg;

    localparam logic [7:0] KBD_BRK    = 8'hF0;
    localparam logic [7:0] KBD_EXT    = 8'hE0;
    localparam logic [7:0] KBD_LSHIFT = 8'h12;
    localparam logic [7:0] KBD_RSHIFT = 8'h59;
    localparam logic [7:0] KBD_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } parse_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic       rep;
        logic [7:0] code;
        logic [7:0] ascii;
    } kbd_evt_t;

    function automatic logic is_modifier(input logic [7:0] code);
        return (code == KBD_LSHIFT) || (code == KBD_RSHIFT) || (code == KBD_CAPS);
    endfunction

endpackage

// File: rtl/kbd_scan2ascii.sv
// Combinational set-2 scan code to ASCII lookup for letters and digits.
module kbd_scan2ascii (
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] lower;
    logic [7:0] digit;
    logic [7:0] sym;

    always_comb begin
        lower = 8'h00;
        digit = 8'h00;
        sym   = 8'h00;
        case (code)
            8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";
            8'h23: lower = "d";  8'h24: lower = "e";  8'h2B: lower = "f";
            8'h34: lower = "g";  8'h33: lower = "h";  8'h43: lower = "i";
            8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
            8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";
            8'h4D: lower = "p";  8'h15: lower = "q";  8'h2D: lower = "r";
            8'h1B: lower = "s";  8'h2C: lower = "t";  8'h3C: lower = "u";
            8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
            8'h35: lower = "y";  8'h1A: lower = "z";
            8'h16: begin digit = "1"; sym = "!"; end
            8'h1E: begin digit = "2"; sym = "@"; end
            8'h26: begin digit = "3"; sym = "#"; end
            8'h25: begin digit = "4"; sym = "$"; end
            8'h2E: begin digit = "5"; sym = "%"; end
            8'h36: begin digit = "6"; sym = "^"; end
            8'h3D: begin digit = "7"; sym = "&"; end
            8'h3E: begin digit = "8"; sym = "*"; end
            8'h46: begin digit = "9"; sym = "("; end
            8'h45: begin digit = "0"; sym = ")"; end
            default: ;
        endcase

        // Caps only affects letters; digits shift on the shift key alone
        ascii = 8'h00;
        if (!ext) begin
            if (lower != 8'h00)
                ascii = (shift ^ caps) ? (lower - 8'h20) : lower;
            else if (digit != 8'h00)
                ascii = shift ? sym : digit;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 decoder: pops FIFO bytes, parses E0/F0 prefixes, queues key events.
// Optional build macro KBD_SHIFT_EN enables shift/caps-lock modifier handling.
module ps2_key_decoder
    import kbd_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int EVT_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           data,
    input  logic                 ready,
    output logic                 nextdata_n,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [7:0]           evt_code,
    output logic                 evt_ext,
    output logic                 evt_break,
    output logic                 evt_rep,
    output logic [7:0]           evt_ascii,
    output logic                 evt_ovf,
    output logic                 key_down,
    output logic [7:0]           cur_code,
    output logic [7:0]           cur_ascii,
    output logic [CNT_WIDTH-1:0] press_cnt
);

    localparam int AW = $clog2(EVT_DEPTH);

    logic [7:0]   rx_byte_p0;
    logic         vld_p0;
    parse_state_t state;
    parse_state_t state_nxt;
    logic         cur_ext;
    logic         shift_q;
    logic         caps_q;

    logic         ext_p1, brk_p1, rep_p1, mod_p1, push_p1;
    logic [7:0]   ascii_p1;
    kbd_evt_t     evt_p1;

    kbd_evt_t     mem [EVT_DEPTH];
    kbd_evt_t     head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]  count;
    logic         full, pop, push_ok;

    // ---- stage p0: pop strobe and byte capture ----
    always_ff @(posedge clk) begin
        if (reset) begin
            nextdata_n <= 1'b1;
            vld_p0     <= 1'b0;
        end else begin
            nextdata_n <= ~(ready & nextdata_n);
            vld_p0     <= ready & nextdata_n;
        end
    end

    always_ff @(posedge clk) begin
        if (ready && nextdata_n)
            rx_byte_p0 <= data;
    end

    // ---- stage p1: prefix parsing and event formation ----
    assign ext_p1 = (state == ST_EXT) || (state == ST_EXT_BRK);
    assign brk_p1 = (state == ST_BRK) || (state == ST_EXT_BRK);
    assign rep_p1 = !brk_p1 && key_down && (cur_code == rx_byte_p0) && (cur_ext == ext_p1);

`ifdef KBD_SHIFT_EN
    assign mod_p1 = !ext_p1 && is_modifier(rx_byte_p0);
`else
    assign mod_p1 = 1'b0;
`endif

    kbd_scan2ascii u_scan2ascii (
        .code  (rx_byte_p0),
        .ext   (ext_p1),
        .shift (shift_q),
        .caps  (caps_q),
        .ascii (ascii_p1)
    );

    always_comb begin
        state_nxt = state;
        push_p1   = 1'b0;
        if (vld_p0) begin
            case (state)
                ST_IDLE: begin
                    if (rx_byte_p0 == KBD_EXT)      state_nxt = ST_EXT;
                    else if (rx_byte_p0 == KBD_BRK) state_nxt = ST_BRK;
                    else                            push_p1   = 1'b1;
                end
                ST_EXT: begin
                    if (rx_byte_p0 == KBD_BRK)      state_nxt = ST_EXT_BRK;
                    else if (rx_byte_p0 != KBD_EXT) begin
                        push_p1   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    push_p1   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            endcase
        end
        evt_p1 = '{ext: ext_p1, brk: brk_p1, rep: rep_p1, code: rx_byte_p0, ascii: ascii_p1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            key_down  <= 1'b0;
            cur_code  <= 8'h00;
            cur_ascii <= 8'h00;
            cur_ext   <= 1'b0;
            press_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (push_p1 && !mod_p1) begin
                if (!brk_p1 && !rep_p1) begin
                    key_down  <= 1'b1;
                    cur_code  <= rx_byte_p0;
                    cur_ascii <= ascii_p1;
                    cur_ext   <= ext_p1;
                    press_cnt <= press_cnt + CNT_WIDTH'(1);
                end else if (brk_p1 && (cur_code == rx_byte_p0) && (cur_ext == ext_p1)) begin
                    key_down <= 1'b0;
                end
            end
        end
    end

`ifdef KBD_SHIFT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= 1'b0;
            caps_q  <= 1'b0;
        end else if (push_p1 && mod_p1) begin
            if (rx_byte_p0 == KBD_CAPS) begin
                if (!brk_p1 && !rep_p1)
                    caps_q <= ~caps_q;
            end else begin
                shift_q <= ~brk_p1;
            end
        end
    end
`else
    assign shift_q = 1'b0;
    assign caps_q  = 1'b0;
`endif

    // ---- stage p2: event queue ----
    assign full    = (count == (AW+1)'(EVT_DEPTH));
    assign pop     = evt_valid && evt_ready;
    assign push_ok = push_p1 && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            evt_ovf <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      count <= count + (AW+1)'(1);
            else if (!push_ok && pop) count <= count - (AW+1)'(1);
            if (push_p1 && !push_ok)  evt_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= evt_p1;
    end

    // Head fields read as zero while the queue is empty so reset leaves them at 0
    assign head      = mem[rd_ptr];
    assign evt_valid = (count != '0);
    assign evt_code  = evt_valid ? head.code  : 8'h00;
    assign evt_ascii = evt_valid ? head.ascii : 8'h00;
    assign evt_ext   = evt_valid && head.ext;
    assign evt_break = evt_valid && head.brk;
    assign evt_rep   = evt_valid && head.rep;

endmodule
